// File: rtl/sata_link_arbt_mc.sv
// Multi-channel SATA link arbiter: round-robin TX grant or X_RDY receive grant,
// with startup delay, transaction watchdog and abort on PHY loss.
package sata_link_arbt_mc_pkg;
  typedef enum logic [3:0] {
    align, sync, x_rdy, r_rdy, r_ip, r_ok, r_err, sof, eof, wtrm, hold, holda, cont, data
  } sata_p_t;
endpackage

module sata_link_arbt_mc
  import sata_link_arbt_mc_pkg::*;
#(
  parameter int unsigned N_TX        = 2,
  parameter int unsigned STARTUP_CYC = 150,
  parameter int unsigned TIMEOUT_CYC = 65536,
  parameter int unsigned RX_PRIO     = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_TX-1:0] tx_req,
  input  sata_p_t         rx_dat_type,
  input  logic            phyrdy,
  input  logic            roll_insert,
  output logic            wr_req,
  output logic [N_TX-1:0] wr_gnt,
  input  logic            wr_cpl,
  input  logic            wr_no_busy,
  output logic            rd_req,
  input  logic            rd_cpl,
  output logic            timeout_err,
  output logic            arb_ready
);

  localparam int unsigned IW = (N_TX > 1) ? $clog2(N_TX) : 1;
  localparam int unsigned SW = $clog2((STARTUP_CYC > 2) ? STARTUP_CYC : 2);
  localparam int unsigned TW = $clog2((TIMEOUT_CYC > 2) ? TIMEOUT_CYC : 2);
  localparam bit WD_EN = (TIMEOUT_CYC != 0);
  localparam logic [SW-1:0] SU_LAST  = SW'(STARTUP_CYC - 1);
  localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_TX - 1);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    WR   = 3'b010,
    RD   = 3'b100
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   gnt_idx, gnt_nx;
  logic [IW-1:0]   rr_ptr, rr_nx;
  logic [SW-1:0]   su_cnt, su_nx;
  logic [TW-1:0]   wd_cnt, wd_nx;
  logic            roll_d;
  logic            arb_nx;
  logic            timeout_nx;
  logic [N_TX-1:0] wr_gnt_nx;

  logic            x_rdy_c;
  logic            tx_any_c;
  logic            can_arb_c;
  logic            wd_hit_c;
  logic [IW-1:0]   pick_c;
  logic [IW-1:0]   gnt_inc_c;

  // First requesting channel at or after ptr, wrapping modulo N_TX.
  function automatic logic [IW-1:0] rr_pick(input logic [N_TX-1:0] req,
                                            input logic [IW-1:0]   ptr);
    int unsigned c;
    rr_pick = ptr;
    for (int i = int'(N_TX) - 1; i >= 0; i--) begin
      c = (32'(ptr) + 32'(i)) % N_TX;
      if (req[IW'(c)]) rr_pick = IW'(c);
    end
  endfunction

  assign x_rdy_c   = (rx_dat_type == x_rdy);
  assign tx_any_c  = |tx_req;
  assign can_arb_c = arb_ready && phyrdy && !(roll_insert || roll_d);
  assign wd_hit_c  = WD_EN && (wd_cnt == WD_LAST);
  assign pick_c    = rr_pick(tx_req, rr_ptr);
  assign gnt_inc_c = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IW'(1);

  // Next-state, pointer, counter and registered-output decode.
  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt_idx;
    rr_nx      = rr_ptr;
    timeout_nx = 1'b0;
    arb_nx     = arb_ready;
    su_nx      = su_cnt;
    wd_nx      = '0;
    wr_gnt_nx  = '0;

    case (state)
      IDLE: begin
        if (can_arb_c) begin
          if (x_rdy_c && (RX_PRIO != 0 || !tx_any_c)) begin
            state_nx = RD;
          end else if (tx_any_c) begin
            state_nx = WR;
            gnt_nx   = pick_c;
          end
        end
      end
      WR: begin
        if (!phyrdy) begin
          state_nx = IDLE;
        end else if (wr_no_busy && x_rdy_c) begin
          state_nx = RD;
        end else if (wr_cpl) begin
          state_nx = IDLE;
          rr_nx    = gnt_inc_c;
        end else if (wd_hit_c) begin
          state_nx   = IDLE;
          rr_nx      = gnt_inc_c;
          timeout_nx = 1'b1;
        end
      end
      RD: begin
        if (!phyrdy) begin
          state_nx = IDLE;
        end else if (rd_cpl) begin
          state_nx = IDLE;
        end else if (wd_hit_c) begin
          state_nx   = IDLE;
          rr_nx      = gnt_inc_c;
          timeout_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Watchdog runs only while parked in WR/RD; any transition clears it.
    if (WD_EN && (state_nx == state) && (state_nx != IDLE)) begin
      wd_nx = wd_cnt + TW'(1);
    end

    // Startup delay restarts whenever the PHY is not ready.
    if (!phyrdy) begin
      arb_nx = 1'b0;
      su_nx  = '0;
    end else if (!arb_ready) begin
      if (su_cnt == SU_LAST) begin
        arb_nx = 1'b1;
        su_nx  = '0;
      end else begin
        su_nx = su_cnt + SW'(1);
      end
    end

    if (state_nx == WR) begin
      wr_gnt_nx = N_TX'(1) << gnt_nx;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_idx     <= '0;
      rr_ptr      <= '0;
      su_cnt      <= '0;
      wd_cnt      <= '0;
      roll_d      <= 1'b0;
      wr_req      <= 1'b0;
      wr_gnt      <= '0;
      rd_req      <= 1'b0;
      timeout_err <= 1'b0;
      arb_ready   <= 1'b0;
    end else begin
      state       <= state_nx;
      gnt_idx     <= gnt_nx;
      rr_ptr      <= rr_nx;
      su_cnt      <= su_nx;
      wd_cnt      <= wd_nx;
      roll_d      <= roll_insert;
      wr_req      <= (state_nx == WR);
      wr_gnt      <= wr_gnt_nx;
      rd_req      <= (state_nx == RD);
      timeout_err <= timeout_nx;
      arb_ready   <= arb_nx;
    end
  end

endmodule

// File: tb/tb_sata_link_arbt_mc.sv
// Randomized scoreboard bench for sata_link_arbt_mc: two configurations are
// driven side by side and compared every cycle against a timestamp-based model.
module tb_sata_link_arbt_mc;
  import sata_link_arbt_mc_pkg::*;

  localparam int NI      = 2;
  localparam int A_N     = 2;
  localparam int A_ST    = 150;
  localparam int A_TO    = 16;
  localparam int A_RXP   = 0;
  localparam int B_N     = 3;
  localparam int B_ST    = 4;
  localparam int B_TO    = 0;
  localparam int B_RXP   = 1;
  localparam int RUN_CYC = 8000;
  localparam int QUIET   = 170;
  localparam int M_IDLE  = 0;
  localparam int M_WR    = 1;
  localparam int M_RD    = 2;

  typedef struct packed {
    logic       wr;
    logic [7:0] gnt;
    logic       rd;
    logic       to;
    logic       rdy;
  } obs_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_req [NI];
  sata_p_t    rx_t   [NI];
  logic       phy    [NI];
  logic       roll   [NI];
  logic       wcpl   [NI];
  logic       wnb    [NI];
  logic       rcpl   [NI];

  logic       wr_req_a, rd_req_a, to_a, rdy_a;
  logic [1:0] gnt_a;
  logic       wr_req_b, rd_req_b, to_b, rdy_b;
  logic [2:0] gnt_b;

  int cfg_n   [NI] = '{A_N, B_N};
  int cfg_st  [NI] = '{A_ST, B_ST};
  int cfg_to  [NI] = '{A_TO, B_TO};
  int cfg_rxp [NI] = '{A_RXP, B_RXP};

  int m_mode  [NI];
  int m_own   [NI];
  int m_rr    [NI];
  int m_run   [NI];
  int m_enter [NI];
  int m_done  [NI];
  int p_down  [NI];
  bit m_ready [NI];
  bit m_rollp [NI];

  obs_t q0[$];
  obs_t q1[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   first_wr_a = -1;
  int   first_rdy_a = -1;

  always #5 clk = ~clk;

  sata_link_arbt_mc #(.N_TX(A_N), .STARTUP_CYC(A_ST), .TIMEOUT_CYC(A_TO), .RX_PRIO(A_RXP)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_req(tx_req[0][1:0]), .rx_dat_type(rx_t[0]),
    .phyrdy(phy[0]), .roll_insert(roll[0]), .wr_req(wr_req_a), .wr_gnt(gnt_a),
    .wr_cpl(wcpl[0]), .wr_no_busy(wnb[0]), .rd_req(rd_req_a), .rd_cpl(rcpl[0]),
    .timeout_err(to_a), .arb_ready(rdy_a));

  sata_link_arbt_mc #(.N_TX(B_N), .STARTUP_CYC(B_ST), .TIMEOUT_CYC(B_TO), .RX_PRIO(B_RXP)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_req(tx_req[1][2:0]), .rx_dat_type(rx_t[1]),
    .phyrdy(phy[1]), .roll_insert(roll[1]), .wr_req(wr_req_b), .wr_gnt(gnt_b),
    .wr_cpl(wcpl[1]), .wr_no_busy(wnb[1]), .rd_req(rd_req_b), .rd_cpl(rcpl[1]),
    .timeout_err(to_b), .arb_ready(rdy_b));

  function automatic obs_t observe(input int k);
    obs_t o;
    if (k == 0) o = '{wr: wr_req_a, gnt: 8'(gnt_a), rd: rd_req_a, to: to_a, rdy: rdy_a};
    else        o = '{wr: wr_req_b, gnt: 8'(gnt_b), rd: rd_req_b, to: to_b, rdy: rdy_b};
    return o;
  endfunction

  // Reference: ownership, rotation pointer, time-in-state and PHY-up run length.
  function automatic obs_t model_step(input int k);
    obs_t e;
    int   n    = cfg_n[k];
    bit   x    = (rx_t[k] == x_rdy);
    bit   gate = m_ready[k] && phy[k] && !(roll[k] || m_rollp[k]);
    bit   tmo  = (cfg_to[k] > 0) && ((cyc - m_enter[k]) == cfg_to[k]);
    int   pick = -1;
    int   nm   = m_mode[k];
    int   idx;
    e = '0;
    m_done[k] = -1;
    for (int i = 0; i < n; i++) begin
      idx = (m_rr[k] + i) % n;
      if (pick < 0 && tx_req[k][idx[2:0]]) pick = idx;
    end
    if (m_mode[k] == M_IDLE) begin
      if (gate) begin
        if (x && (cfg_rxp[k] == 1 || pick < 0)) nm = M_RD;
        else if (pick >= 0) begin nm = M_WR; m_own[k] = pick; end
      end
    end else if (!phy[k]) begin
      nm = M_IDLE;
    end else if (m_mode[k] == M_WR) begin
      if (wnb[k] && x) nm = M_RD;
      else if (wcpl[k]) begin
        nm = M_IDLE; m_done[k] = m_own[k]; m_rr[k] = (m_own[k] + 1) % n;
      end else if (tmo) begin
        nm = M_IDLE; m_rr[k] = (m_own[k] + 1) % n; e.to = 1'b1;
      end
    end else begin
      if (rcpl[k]) nm = M_IDLE;
      else if (tmo) begin
        nm = M_IDLE; m_rr[k] = (m_own[k] + 1) % n; e.to = 1'b1;
      end
    end
    if (nm != m_mode[k]) m_enter[k] = cyc;
    m_mode[k] = nm;
    if (!phy[k]) begin
      m_run[k] = 0; m_ready[k] = 1'b0;
    end else if (!m_ready[k]) begin
      m_run[k]++;
      if (m_run[k] >= cfg_st[k]) m_ready[k] = 1'b1;
    end
    m_rollp[k] = roll[k];
    e.wr  = (nm == M_WR);
    e.gnt = e.wr ? 8'(1 << m_own[k]) : 8'd0;
    e.rd  = (nm == M_RD);
    e.rdy = m_ready[k];
    return e;
  endfunction

  // Requesters and link engines reacting to the model's view of the grant.
  task automatic drive(input int k);
    bit   quiet = (cyc < QUIET);
    logic [3:0] prim;
    for (int c = 0; c < cfg_n[k]; c++) begin
      if (c == m_done[k]) tx_req[k][c] = 1'b0;
      else if (!tx_req[k][c] && $urandom_range(0, 5) == 0) tx_req[k][c] = 1'b1;
    end
    wcpl[k] = (m_mode[k] == M_WR) && ($urandom_range(0, 5) == 0);
    rcpl[k] = (m_mode[k] == M_RD) && ($urandom_range(0, 4) == 0);
    wnb[k]  = 1'($urandom_range(0, 1));
    prim    = 4'($urandom_range(3, 13));
    rx_t[k] = (!quiet && $urandom_range(0, 7) == 0) ? x_rdy : sata_p_t'(prim);
    roll[k] = !quiet && ($urandom_range(0, 15) == 0);
    if (p_down[k] > 0) begin
      phy[k] = 1'b0;
      p_down[k]--;
    end else begin
      phy[k] = 1'b1;
      if (!quiet && $urandom_range(0, 499) == 0) p_down[k] = $urandom_range(1, 3);
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      tx_req[k] = '0; rx_t[k] = sync; phy[k] = 1'b1; roll[k] = 1'b0;
      wcpl[k] = 1'b0; wnb[k] = 1'b0; rcpl[k] = 1'b0;
      m_mode[k] = M_IDLE; m_own[k] = 0; m_rr[k] = 0; m_run[k] = 0; m_enter[k] = 0;
      m_done[k] = -1; p_down[k] = 0; m_ready[k] = 1'b0; m_rollp[k] = 1'b0;
    end
    tx_req[0][0] = 1'b1;
    tx_req[1][0] = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (RUN_CYC) begin
      @(negedge clk);
      drive(0);
      drive(1);
    end
    @(negedge clk);
    n_checks++;
    if (first_rdy_a != A_ST) begin
      n_fail++;
      $display("FAIL first_arb_ready_edge got %0d required %0d", first_rdy_a, A_ST);
    end
    n_checks++;
    if (first_wr_a != A_ST + 1) begin
      n_fail++;
      $display("FAIL first_grant_edge got %0d required %0d", first_wr_a, A_ST + 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Reference model steps on every active edge out of reset.
  initial forever begin
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      q0.push_back(model_step(0));
      q1.push_back(model_step(1));
    end
  end

  // Monitor: pops one expectation per instance per cycle and compares.
  initial forever begin
    obs_t act;
    obs_t exp;
    bit   have;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      act  = observe(k);
      exp  = '0;
      have = 1'b1;
      if (rst_n) begin
        if (k == 0) begin
          if (q0.size() > 0) exp = q0.pop_front(); else have = 1'b0;
        end else begin
          if (q1.size() > 0) exp = q1.pop_front(); else have = 1'b0;
        end
      end
      n_checks++;
      if (!have) begin
        n_fail++;
        $display("FAIL inst%0d no_expectation cyc=%0d got %b", k, cyc, act);
      end else if (act !== exp) begin
        n_fail++;
        $display("FAIL inst%0d outputs cyc=%0d got wr=%b gnt=%b rd=%b to=%b rdy=%b required wr=%b gnt=%b rd=%b to=%b rdy=%b",
                 k, cyc, act.wr, act.gnt, act.rd, act.to, act.rdy,
                 exp.wr, exp.gnt, exp.rd, exp.to, exp.rdy);
      end
    end
    if (rst_n && first_wr_a < 0 && wr_req_a === 1'b1) first_wr_a = cyc;
    if (rst_n && first_rdy_a < 0 && rdy_a === 1'b1) first_rdy_a = cyc;
  end

endmodule

// File: doc/sata_link_arbt_mc.md
# sata_link_arbt_mc

Multi-channel SATA link arbiter. It grants the link layer to one of N_TX transmit requesters using round-robin order, or to the receive path when the device sends X_RDY. It sits between the transport-layer command queues and the link-layer TX/RX engines. It adds three things to a single-requester arbiter: a configurable startup delay, a transaction watchdog, and an abort on PHY loss.

## Interface
Parameters:
- N_TX, 2, number of transmit requesters (1..8)
- STARTUP_CYC, 150, idle cycles after reset or PHY recovery before arbitration starts (≥1)
- TIMEOUT_CYC, 65536, maximum cycles in WR/RD without a completion; 0 disables the watchdog
- RX_PRIO, 0, IDLE tie-break when a TX request and X_RDY arrive together: 0 = write wins, 1 = read wins

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_req  in  N_TX  per-channel transmit request, level, held until its wr_cpl
- rx_dat_type  in  sata_p_t  received primitive type; X_RDY detection uses == x_rdy
- phyrdy  in  1  PHY ready
- roll_insert  in  1  roll insertion in progress
- wr_req  out  1  link TX engine request
- wr_gnt  out  N_TX  one-hot granted channel; valid while wr_req=1
- wr_cpl  in  1  write complete (1-cycle pulse)
- wr_no_busy  in  1  TX engine can yield to RX
- rd_req  out  1  link RX engine request
- rd_cpl  in  1  read complete (1-cycle pulse)
- timeout_err  out  1  1-cycle pulse when the watchdog fires
- arb_ready  out  1  startup delay elapsed (start flag)

## Operation
- States: IDLE, WR, RD, one-hot encoded. Illegal encodings go to IDLE.
- pause = roll_insert | roll_insert delayed by one cycle. While pause=1, IDLE exits are blocked.
- IDLE→WR requires all of: arb_ready, phyrdy, !pause, |tx_req. Grant selection:
  - Pick the first set tx_req at or after rr_ptr, with modulo N_TX wrap.
  - Register the choice as gnt_idx.
- IDLE→RD requires arb_ready, phyrdy, !pause and rx_dat_type==x_rdy. On a tie with a TX request, RX_PRIO decides.
- WR→RD when wr_no_busy & x_rdy. This takes priority over wr_cpl in the same cycle.
  - gnt_idx and rr_ptr are kept, so the yielded channel is re-granted first afterwards.
- WR→IDLE on wr_cpl. Then rr_ptr ← gnt_idx+1, wrapping to 0 after N_TX-1.
- RD→IDLE on rd_cpl.
- PHY loss: when phyrdy=0 in WR or RD, go to IDLE next cycle. Also:
  - rr_ptr is not advanced.
  - arb_ready clears and the startup counter restarts from 0.
  - The counter counts only while phyrdy=1.
- Startup counter:
  - Counts while !arb_ready and phyrdy.
  - At STARTUP_CYC-1 it sets arb_ready and resets to 0.
  - A phyrdy drop while counting resets it to 0.
- Watchdog:
  - Counts cycles in WR/RD and clears on any state change.
  - At TIMEOUT_CYC-1 with no completion that cycle: go to IDLE, pulse timeout_err, advance rr_ptr past gnt_idx. This skips a stuck channel.
  - A completion in the same cycle wins: normal exit, no error.
- wr_req = (state==WR). wr_gnt = one-hot(gnt_idx) & {N_TX{wr_req}}. rd_req = (state==RD).

## Timing
- Reset values: state IDLE, wr_req 0, rd_req 0, wr_gnt 0, timeout_err 0, arb_ready 0, rr_ptr 0, counters 0.
- All outputs decode from registers. There is no combinational path from any input to any output.
- Grant latency: qualifying inputs sampled at edge t give wr_req/rd_req high after edge t.
- Completion: cpl sampled at edge t gives req low after edge t. A new grant is possible at edge t+1 at the earliest, so there is at least one IDLE cycle.
- arb_ready rises after STARTUP_CYC edges with phyrdy=1 continuously. The first grant is possible on the edge after that.
- Pause: roll_insert high at edge t blocks grants at edges t and t+1.
- Counter widths: $clog2(max(STARTUP_CYC,2)) and $clog2(max(TIMEOUT_CYC,2)) bits. They never wrap.

## Test plan
- Reset, phyrdy=1, tx_req=2'b01 from cycle 0 -> wr_req=0 through the 150th edge; wr_req=1 and wr_gnt=01 one edge after arb_ready.
- tx_req=2'b11 held, wr_cpl after each grant -> grant order 01,10,01,10; one IDLE cycle between grants.
- In WR on channel 1, x_rdy with wr_no_busy=1 and wr_cpl=1 in the same cycle -> RD next; after rd_cpl, channel 1 is re-granted.
- Simultaneous tx_req and x_rdy in IDLE -> WR when RX_PRIO=0, RD when RX_PRIO=1; roll_insert pulse delays either grant by 2 cycles.
- TIMEOUT_CYC=16, no wr_cpl -> timeout_err one-cycle pulse 16 cycles after grant; IDLE; next grant goes to the other channel.
- phyrdy dropped mid-WR -> wr_req=0 next cycle, arb_ready=0, no grant until 150 cycles after phyrdy returns.
